rgb_pwm_fader: RTL and testbench
================================

RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 Parameter PRESCALE, default 4, meaning i_clk cycles per PWM tick (legal range 1..65535).
REQ-002 Parameter FADE_DIV, default 16, meaning PWM periods per fade step (legal range 1..65535).
REQ-003 i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_red_target  input  8  requested red brightness, driven by the SPI command decoder's red output.
REQ-006 i_green_target  input  8  requested green brightness.
REQ-007 i_blue_target  input  8  requested blue brightness.
REQ-008 i_fade_en  input  1  1 = ramp toward targets, 0 = jump to targets.
REQ-009 o_pwm_red  output  1  red PWM drive, active-high, registered.
REQ-010 o_pwm_green  output  1  green PWM drive, active-high, registered.
REQ-011 o_pwm_blue  output  1  blue PWM drive, active-high, registered.
REQ-012 o_busy  output  1  high while any channel's current brightness differs from its target.
REQ-013 o_period_start  output  1  one-cycle pulse at each PWM period boundary.

Function
REQ-014 Prescaler counts 0..PRESCALE-1 and wraps; a tick is asserted in the cycle it equals PRESCALE-1.
REQ-015 PWM counter is 8 bits; it advances on each tick; at 254 it wraps to 0, giving a period of 255 ticks = 255*PRESCALE clocks.
REQ-016 Period boundary: the tick cycle in which the PWM counter wraps 254 -> 0; o_period_start is high for the following cycle only.
REQ-017 Each channel's PWM output is registered high exactly when counter < latched duty: duty 0 gives constant low; duty 255 gives constant high.
REQ-018 Duty registers load only at a period boundary, so a target change mid-period never alters the current period.
REQ-019 Fade-step counter counts period boundaries 0..FADE_DIV-1; a fade step occurs on the boundary at which it wraps.
REQ-020 With i_fade_en=1 at a fade step, each current value moves by exactly 1 toward its target (+1 if below, -1 if above, hold if equal), with no overshoot or wrap past 0/255.
REQ-021 With i_fade_en=0, at every period boundary each current value loads its target directly.
REQ-022 At a boundary, the duty register loads the updated current value from the same cycle, so a step is visible in the period that starts there.
REQ-023 i_fade_en sampled at each boundary; toggling mid-ramp takes effect at the next boundary without glitching the running period.
REQ-024 o_busy is combinational-free (registered) and reflects current != target for any of the three channels, updated every cycle.
REQ-025 Channels are independent; simultaneous target changes on all three are handled in the same boundary.

Reset
REQ-026 While i_rst=1: prescaler, PWM counter, fade counter, current values and duty registers are 0, and all outputs are 0.
REQ-027 Reset asserted mid-period aborts the period; the first tick after release occurs PRESCALE cycles later, and the first boundary follows 255 ticks after release.

Structure
REQ-028 A shared package holds PWM_WIDTH=8, PWM_LAST=254 and the default PRESCALE/FADE_DIV values.
REQ-029 One sub-module, pwm_channel (current value, ramp step, duty latch, comparator), is instantiated three times; the prescaler and the period and fade counters stay in the top level.

Verification
REQ-030 With PRESCALE=4, fade off, red target 128: after the first boundary o_pwm_red is high for 512 clocks per 1020-clock period.
REQ-031 Targets 0 and 255 on green/blue: o_pwm_green is never high and o_pwm_blue is always high over 3 full periods after the first boundary.
REQ-032 Fade on, FADE_DIV=1, red 0 -> 10: red duty is 1,2,...,10 on successive periods; o_busy falls after the 10th boundary.
REQ-033 Fade on, red target changes from 200 to 50 mid-period while current=100: the current period keeps duty 100, the next period uses 99, and the ramp continues downward.
REQ-034 With red current=60 and target=200 mid-ramp, assert i_rst for 3 cycles: all outputs are 0 during and after reset until the first boundary, and the ramp restarts from 0.
REQ-035 Fade on, toggle i_fade_en to 0 at current=20, target 90: the next boundary jumps red duty to 90, and o_busy clears the following cycle.

Source files
------------

// File: rtl/rgb_pwm_fader_pkg.sv
// Shared constants and the one-step ramp helper used by the RGB PWM fader.
package rgb_pwm_fader_pkg;

  localparam int              PWM_WIDTH        = 8;
  localparam logic [7:0]      PWM_LAST         = 8'd254;
  localparam int              DEFAULT_PRESCALE = 4;
  localparam int              DEFAULT_FADE_DIV = 16;

  // Moves a brightness level one unit toward its target; never wraps.
  function automatic logic [PWM_WIDTH-1:0] stepToward(
    input logic [PWM_WIDTH-1:0] cur,
    input logic [PWM_WIDTH-1:0] tgt
  );
    logic [PWM_WIDTH-1:0] res;
    res = cur;
    if (cur < tgt) begin
      res = cur + 1'b1;
    end else if (cur > tgt) begin
      res = cur - 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rgb_pwm_fader_channel.sv
// One colour channel: current level, ramp step, period-aligned duty latch and
// the registered PWM comparator.
module pwm_channel
  import rgb_pwm_fader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 boundary_i,
  input  logic                 fadeStep_i,
  input  logic                 fadeEn_i,
  input  logic [PWM_WIDTH-1:0] target_i,
  input  logic [PWM_WIDTH-1:0] pwmCnt_i,
  output logic                 pwm_o,
  output logic                 differs_o
);

  logic [PWM_WIDTH-1:0] current_q, current_d;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  logic                 pwm_q, pwm_d;

  // Duty only reloads at a boundary so a running period is never disturbed.
  always_comb begin
    current_d = current_q;
    duty_d    = duty_q;
    if (boundary_i) begin
      if (!fadeEn_i) begin
        current_d = target_i;
      end else if (fadeStep_i) begin
        current_d = stepToward(current_q, target_i);
      end
      duty_d = current_d;
    end
    pwm_d = (pwmCnt_i < duty_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      current_q <= '0;
      duty_q    <= '0;
      pwm_q     <= 1'b0;
    end else begin
      current_q <= current_d;
      duty_q    <= duty_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_o     = pwm_q;
  assign differs_o = (current_q != target_i);

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel RGB PWM driver with optional linear fading toward targets.
// Shared timebase (prescaler, period counter, fade divider) lives here.
module rgb_pwm_fader
  import rgb_pwm_fader_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE,
  parameter int FADE_DIV = DEFAULT_FADE_DIV
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [PWM_WIDTH-1:0] i_red_target,
  input  logic [PWM_WIDTH-1:0] i_green_target,
  input  logic [PWM_WIDTH-1:0] i_blue_target,
  input  logic                 i_fade_en,
  output logic                 o_pwm_red,
  output logic                 o_pwm_green,
  output logic                 o_pwm_blue,
  output logic                 o_busy,
  output logic                 o_period_start
);

  localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] FADE_LAST     = 16'(FADE_DIV - 1);

  logic [15:0]          prescaleCnt_q, prescaleCnt_d;
  logic [PWM_WIDTH-1:0] pwmCnt_q, pwmCnt_d;
  logic [15:0]          fadeCnt_q, fadeCnt_d;
  logic                 periodStart_q, busy_q;
  logic                 tick, boundary, fadeStep;

  logic [2:0][PWM_WIDTH-1:0] targetVec;
  logic [2:0]                pwmVec;
  logic [2:0]                differsVec;

  // A fade step is the boundary on which the fade divider wraps.
  always_comb begin
    tick          = (prescaleCnt_q == PRESCALE_LAST);
    boundary      = tick && (pwmCnt_q == PWM_LAST);
    fadeStep      = boundary && (fadeCnt_q == FADE_LAST);
    prescaleCnt_d = tick ? '0 : prescaleCnt_q + 16'd1;
    pwmCnt_d      = pwmCnt_q;
    fadeCnt_d     = fadeCnt_q;
    if (tick) begin
      pwmCnt_d = (pwmCnt_q == PWM_LAST) ? '0 : pwmCnt_q + 1'b1;
    end
    if (boundary) begin
      fadeCnt_d = (fadeCnt_q == FADE_LAST) ? '0 : fadeCnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prescaleCnt_q <= '0;
      pwmCnt_q      <= '0;
      fadeCnt_q     <= '0;
      periodStart_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      prescaleCnt_q <= prescaleCnt_d;
      pwmCnt_q      <= pwmCnt_d;
      fadeCnt_q     <= fadeCnt_d;
      periodStart_q <= boundary;
      busy_q        <= |differsVec;
    end
  end

  assign targetVec = {i_blue_target, i_green_target, i_red_target};

  for (genvar ch = 0; ch < 3; ch++) begin : g_channel
    pwm_channel u_channel (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .boundary_i (boundary),
      .fadeStep_i (fadeStep),
      .fadeEn_i   (i_fade_en),
      .target_i   (targetVec[ch]),
      .pwmCnt_i   (pwmCnt_q),
      .pwm_o      (pwmVec[ch]),
      .differs_o  (differsVec[ch])
    );
  end

  assign o_pwm_red      = pwmVec[0];
  assign o_pwm_green    = pwmVec[1];
  assign o_pwm_blue     = pwmVec[2];
  assign o_busy         = busy_q;
  assign o_period_start = periodStart_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Self-checking bench: two fader instances with different timebases driven by
// shared stimulus and compared cycle by cycle against an arithmetic model.
module tb_rgb_pwm_fader;

  localparam int NDUT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       fadeEn;
  logic [7:0] red, green, blue;
  logic [2:0] pwmA, pwmB;
  logic       busyA, busyB, psA, psB;

  int testsRun  = 0;
  int testsFail = 0;

  int prescaleOf [NDUT] = '{4, 3};
  int fadeDivOf  [NDUT] = '{1, 3};

  int   edgeCnt     [NDUT];
  int   boundaryCnt [NDUT];
  int   cur         [NDUT][3];
  int   duty        [NDUT][3];
  logic expPwm      [NDUT][3];
  logic expBusy     [NDUT];
  logic expPs       [NDUT];

  int highRed, highGreen, highBlue;

  always #5 clk = ~clk;

  rgb_pwm_fader #(.PRESCALE(4), .FADE_DIV(1)) dutA (
    .i_clk(clk), .i_rst(rst),
    .i_red_target(red), .i_green_target(green), .i_blue_target(blue),
    .i_fade_en(fadeEn),
    .o_pwm_red(pwmA[0]), .o_pwm_green(pwmA[1]), .o_pwm_blue(pwmA[2]),
    .o_busy(busyA), .o_period_start(psA)
  );

  rgb_pwm_fader #(.PRESCALE(3), .FADE_DIV(3)) dutB (
    .i_clk(clk), .i_rst(rst),
    .i_red_target(red), .i_green_target(green), .i_blue_target(blue),
    .i_fade_en(fadeEn),
    .o_pwm_red(pwmB[0]), .o_pwm_green(pwmB[1]), .o_pwm_blue(pwmB[2]),
    .o_busy(busyB), .o_period_start(psB)
  );

  function automatic int targetOf(int ch);
    return (ch == 0) ? int'(red) : (ch == 1) ? int'(green) : int'(blue);
  endfunction

  // Predicts outputs after the coming rising edge from the inputs now applied.
  task automatic modelStep();
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        edgeCnt[d] = 0;
        boundaryCnt[d] = 0;
        expBusy[d] = 1'b0;
        expPs[d] = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
          cur[d][ch] = 0;
          duty[d][ch] = 0;
          expPwm[d][ch] = 1'b0;
        end
      end else begin
        int periodLen, pos, tickIdx;
        logic anyDiff;
        periodLen = 255 * prescaleOf[d];
        pos = edgeCnt[d] % periodLen;
        tickIdx = pos / prescaleOf[d];
        anyDiff = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
          expPwm[d][ch] = (tickIdx < duty[d][ch]);
          if (cur[d][ch] != targetOf(ch)) anyDiff = 1'b1;
        end
        expBusy[d] = anyDiff;
        expPs[d] = (pos == periodLen - 1);
        if (pos == periodLen - 1) begin
          boundaryCnt[d]++;
          for (int ch = 0; ch < 3; ch++) begin
            if (!fadeEn) begin
              cur[d][ch] = targetOf(ch);
            end else if (boundaryCnt[d] % fadeDivOf[d] == 0) begin
              if (cur[d][ch] < targetOf(ch)) cur[d][ch]++;
              else if (cur[d][ch] > targetOf(ch)) cur[d][ch]--;
            end
            duty[d][ch] = cur[d][ch];
          end
        end
        edgeCnt[d]++;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFail++;
      $error("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input int obs, input int exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advances n clocks, checking both instances one time unit after each edge.
  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) begin
      modelStep();
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 3; ch++) begin
        checkOutput($sformatf("dutA.pwm%0d", ch), pwmA[ch], expPwm[0][ch]);
        checkOutput($sformatf("dutB.pwm%0d", ch), pwmB[ch], expPwm[1][ch]);
      end
      checkOutput("dutA.busy", busyA, expBusy[0]);
      checkOutput("dutB.busy", busyB, expBusy[1]);
      checkOutput("dutA.periodStart", psA, expPs[0]);
      checkOutput("dutB.periodStart", psB, expPs[1]);
      highRed   += int'(pwmA[0]);
      highGreen += int'(pwmA[1]);
      highBlue  += int'(pwmA[2]);
    end
  endtask

  initial begin
    rst = 1'b1;
    fadeEn = 1'b0;
    red = 8'd0;
    green = 8'd0;
    blue = 8'd0;
    applyStimulus(5);

    // Direct load: red 128, green 0, blue 255 with fading off.
    rst = 1'b0;
    red = 8'd128;
    green = 8'd0;
    blue = 8'd255;
    applyStimulus(1020);
    highRed = 0;
    highGreen = 0;
    highBlue = 0;
    applyStimulus(3060);
    checkCount("redHighOver3Periods", highRed, 3 * 512);
    checkCount("greenHighOver3Periods", highGreen, 0);
    checkCount("blueHighOver3Periods", highBlue, 3060);

    // Ramp from zero to ten with one step per period.
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    fadeEn = 1'b1;
    red = 8'd10;
    green = 8'($urandom_range(0, 5));
    blue = 8'($urandom_range(0, 5));
    applyStimulus(11 * 1020 + 5);

    // Reverse the red ramp in the middle of a period.
    red = 8'd20;
    applyStimulus(3 * 1020 + 300);
    red = 8'd2;
    applyStimulus(4 * 1020);

    // Random targets and fade modes.
    for (int r = 0; r < 8; r++) begin
      fadeEn = 1'($urandom_range(0, 1));
      red = 8'($urandom_range(0, 255));
      green = 8'($urandom_range(0, 255));
      blue = 8'($urandom_range(0, 255));
      applyStimulus($urandom_range(300, 2500));
    end

    // Reset pulse in the middle of a ramp restarts everything from zero.
    fadeEn = 1'b1;
    red = 8'd200;
    applyStimulus(2000);
    rst = 1'b1;
    applyStimulus(3);
    rst = 1'b0;
    applyStimulus(2100);

    // Turning fading off mid-ramp jumps to the targets at the next boundary.
    red = 8'd90;
    applyStimulus(1500);
    fadeEn = 1'b0;
    applyStimulus(1100);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
